// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the seven-segment display blocks: digit count,
// blank pattern and the active-low hex-to-segment table ({g,f,e,d,c,b,a}).
package seg_pkg;

  localparam int         DIGITS    = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg_scan_display_hex_decode.sv
// Combinational 4-bit to active-low seven-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed common-anode driver: snapshot register, digit scan,
// leading-zero blanking and a scan-timed carry indicator on the MSD point.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIV        = 50000,
  parameter int HOLD_SCANS = 8
) (
  input  logic        clk,
  input  logic        mr_n,
  input  logic [15:0] din,
  input  logic        upd,
  input  logic        co_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD_SCANS + 1);

  logic [PW-1:0]              pcnt;
  logic [1:0]                 idx;
  logic [DIGITS-1:0][3:0]     shadow;
  logic [HW-1:0]              hold;
  logic                       co_prev;

  logic                       tick, scan_done, co_rise;
  logic [DIGITS-1:0][6:0]     dseg;
  logic [DIGITS-1:0]          blank;
  logic [3:0]                 an_nx;
  logic [6:0]                 seg_nx;
  logic                       dp_nx;

  assign tick      = (pcnt == PW'(DIV - 1));
  assign scan_done = tick && (idx == 2'd3);
  assign co_rise   = co_in && !co_prev;

  // Per-digit decode and blanking: digit k blanks when nibbles k..3 are zero.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    seg_hex_decode u_dec (.nib(shadow[g]), .seg(dseg[g]));
    if (g == 0) begin : g_lsd
      assign blank[g] = 1'b0;
    end else begin : g_upper
      assign blank[g] = blank_lz && (shadow[DIGITS-1:g] == '0);
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      pcnt    <= '0;
      idx     <= '0;
      shadow  <= '0;
      co_prev <= 1'b0;
    end else begin
      pcnt    <= tick ? '0 : pcnt + PW'(1);
      if (tick) idx <= idx + 2'd1;
      if (upd)  shadow <= din;
      co_prev <= co_in;
    end
  end

  // A fresh carry event takes priority over the scan-completion decrement.
  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n)                         hold <= '0;
    else if (co_rise)                  hold <= HW'(HOLD_SCANS);
    else if (scan_done && hold != '0)  hold <= hold - HW'(1);
  end

  always_comb begin
    an_nx  = ~(4'b0001 << idx);
    seg_nx = blank[idx] ? SEG_BLANK : dseg[idx];
    dp_nx  = !((hold != '0) && (idx == 2'd3));
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
      dp_n <= 1'b1;
    end else begin
      an   <= an_nx;
      seg  <= seg_nx;
      dp_n <= dp_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIV=4, HOLD_SCANS=2.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        mr_n = 1'b0;
  logic [15:0] din = '0;
  logic        upd = 1'b0;
  logic        co_in = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int tests = 0;
  int fails = 0;
  int cyc;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_display #(.DIV(4), .HOLD_SCANS(2)) dut (
    .clk(clk), .mr_n(mr_n), .din(din), .upd(upd), .co_in(co_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  // Edges since reset release: edge k shows digit ((k-1)/4)%4.
  always @(posedge clk or negedge mr_n)
    if (!mr_n) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic logic [1:0] eidx(int c);
    return 2'(((c - 1) / 4) % 4);
  endfunction

  function automatic logic [6:0] eseg(logic [15:0] v, logic [1:0] d, logic b);
    logic [15:0] hi;
    hi = v >> (4 * d);
    if (b && d != 2'd0 && hi == 16'h0) return 7'h7F;
    return HEX[hi[3:0]];
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [15:0] d, input logic u, input logic c, input logic b);
    @(negedge clk);
    mr_n = 1'b0; din = d; upd = u; co_in = c; blank_lz = b;
    @(negedge clk);
    mr_n = 1'b1;
  endtask

  task automatic test_reset;
    start(16'h1234, 1'b1, 1'b0, 1'b0);
    repeat (7) step;
    #2 mr_n = 1'b0;
    #1;
    tests++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_async got an=%b seg=%h dp=%b exp an=1111 seg=7f dp=1", an, seg, dp_n);
    end
    @(negedge clk); mr_n = 1'b1;
    step;
    tests++;
    if (an !== 4'b1110 || seg !== 7'h40 || dp_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_release got an=%b seg=%h dp=%b exp an=1110 seg=40 dp=1", an, seg, dp_n);
    end
    step;
    upd = 1'b0;
    tests++;
    if (seg !== 7'h19) begin
      fails++;
      $display("FAIL upd_latency got seg=%h exp 19", seg);
    end
  endtask

  task automatic test_scan;
    start(16'h3210, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step;
      upd = 1'b0;
      tests++;
      if (an !== ~(4'b0001 << eidx(cyc)) || seg !== eseg(16'h3210, eidx(cyc), 1'b0)) begin
        fails++;
        $display("FAIL scan cyc=%0d got an=%b seg=%h exp an=%b seg=%h", cyc, an, seg,
                 ~(4'b0001 << eidx(cyc)), eseg(16'h3210, eidx(cyc), 1'b0));
      end
    end
  endtask

  task automatic test_snapshot;
    din = 16'hFFFF;
    for (int k = 33; k <= 48; k++) begin
      step;
      tests++;
      if (seg !== eseg(16'h3210, eidx(cyc), 1'b0)) begin
        fails++;
        $display("FAIL snapshot_hold cyc=%0d got seg=%h exp %h", cyc, seg, eseg(16'h3210, eidx(cyc), 1'b0));
      end
    end
    upd = 1'b1;
    step;
    upd = 1'b0;
    tests++;
    if (seg !== 7'h40) begin
      fails++;
      $display("FAIL snapshot_capture_edge got seg=%h exp 40", seg);
    end
    for (int k = 50; k <= 64; k++) begin
      step;
      tests++;
      if (seg !== 7'h0E) begin
        fails++;
        $display("FAIL snapshot_new cyc=%0d got seg=%h exp 0e", cyc, seg);
      end
    end
  endtask

  task automatic test_blanking;
    start(16'h0003, 1'b1, 1'b0, 1'b1);
    step;
    upd = 1'b0;
    for (int k = 2; k <= 32; k++) begin
      step;
      tests++;
      if (seg !== eseg(16'h0003, eidx(cyc), 1'b1)) begin
        fails++;
        $display("FAIL blank_0003 cyc=%0d got seg=%h exp %h", cyc, seg, eseg(16'h0003, eidx(cyc), 1'b1));
      end
    end
    din = 16'h0000; upd = 1'b1;
    step;
    upd = 1'b0;
    tests++;
    if (seg !== 7'h30) begin
      fails++;
      $display("FAIL blank_capture_edge got seg=%h exp 30", seg);
    end
    for (int k = 34; k <= 48; k++) begin
      step;
      tests++;
      if (seg !== eseg(16'h0000, eidx(cyc), 1'b1)) begin
        fails++;
        $display("FAIL blank_0000 cyc=%0d got seg=%h exp %h", cyc, seg, eseg(16'h0000, eidx(cyc), 1'b1));
      end
    end
    blank_lz = 1'b0;
    for (int k = 49; k <= 64; k++) begin
      step;
      tests++;
      if (seg !== 7'h40) begin
        fails++;
        $display("FAIL noblank_0000 cyc=%0d got seg=%h exp 40", cyc, seg);
      end
    end
  endtask

  // co_in high from before edge 1 and never dropped: one event only.
  task automatic test_overflow;
    logic exp;
    start(16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      step;
      exp = !(eidx(cyc) == 2'd3 && cyc <= 32);
      tests++;
      if (dp_n !== exp) begin
        fails++;
        $display("FAIL overflow cyc=%0d got dp_n=%b exp %b", cyc, dp_n, exp);
      end
    end
  endtask

  // Second rising edge at edge 20 (hold=1) reloads to 2.
  task automatic test_reload;
    logic exp;
    start(16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      if (k == 10) co_in = 1'b0;
      if (k == 20) co_in = 1'b1;
      step;
      exp = !(eidx(cyc) == 2'd3 && cyc <= 48);
      tests++;
      if (dp_n !== exp) begin
        fails++;
        $display("FAIL reload cyc=%0d got dp_n=%b exp %b", cyc, dp_n, exp);
      end
    end
  endtask

  // Rising edge lands on edge 32, the scan completion that would drop hold 1->0.
  task automatic test_simul;
    logic exp;
    start(16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      if (k == 10) co_in = 1'b0;
      if (k == 32) co_in = 1'b1;
      step;
      exp = !(eidx(cyc) == 2'd3 && cyc <= 64);
      tests++;
      if (dp_n !== exp) begin
        fails++;
        $display("FAIL simul cyc=%0d got dp_n=%b exp %b", cyc, dp_n, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_snapshot;
    test_blanking;
    test_overflow;
    test_reload;
    test_simul;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Four-digit multiplexed seven-segment driver sitting directly downstream of the cascaded up/down binary counters. It snapshots four 4-bit counter values plus the top counter's carry-out, then time-multiplexes them onto a common-anode display as hex digits. It supports optional leading-zero blanking and a carry/borrow indicator on the most-significant decimal point that stays lit for a fixed number of scans.

## Interface
- DIV, 50000: prescaler period in clk cycles per digit slot; must be ≥2.
- HOLD_SCANS, 8: number of full 4-digit scans the overflow indicator stays lit after a carry event; must be ≥1.

- clk  input  1  system clock; all state updates on rising edge.
- mr_n  input  1  reset, asynchronous, active-low.
- din  input  16  counter values; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
- upd  input  1  snapshot strobe; when high at a clk edge, din is captured.
- co_in  input  1  carry/borrow from the most-significant counter (level); its rising edge is the event.
- blank_lz  input  1  leading-zero blanking enable.
- an  output  4  digit enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.

## Operation
- Shadow register (16 b): loads din on any edge with upd=1; otherwise it holds. Only the shadow register is displayed, so din changes without upd have no effect.
- Prescaler: counts 0..DIV-1 and wraps. The tick is asserted in the cycle the count equals DIV-1.
- Digit index (2 b): increments on tick and wraps 3→0. A full scan completes on a tick with index=3.
- Decode: hex 0–F, active-low. Required values:
  - 0 = 0x40
  - 1 = 0x79
  - 2 = 0x24
  - 3 = 0x30
  - F = 0x0E
- Blank pattern: 0x7F.
- Leading-zero blanking: with blank_lz=1, digit k (k=3,2,1) is blanked when shadow nibbles k..3 are all zero. Digit 0 is never blanked.
- Overflow indicator:
  - co_prev register tracks co_in. A rising edge (co_in=1, co_prev=0) loads the hold counter with HOLD_SCANS.
  - The hold counter decrements on each full-scan completion while nonzero.
  - If a rising edge and a scan completion occur in the same cycle, the reload wins.
  - dp_n=0 only while the hold counter is nonzero AND index=3; otherwise dp_n=1.
- an, seg and dp_n are registered outputs computed from the current index, shadow and hold counter.

## Timing
- Reset (mr_n=0, asynchronous): the following are forced immediately:
  - an=4'b1111, seg=7'h7F, dp_n=1
  - shadow=0, prescaler=0, index=0, hold counter=0, co_prev=0
- First edge after reset release: outputs show digit 0 of the shadow (an=1110, seg=0x40).
- Output latency: one cycle after index, shadow or hold-counter change.
  - An upd capture at edge N appears on seg at edge N+1.
  - An index step at tick edge N appears on an at edge N+1.
- Each digit slot lasts exactly DIV cycles; a full scan lasts 4·DIV cycles.
- Reset mid-scan: the scan restarts at digit 0 with the hold counter cleared. No partial state survives.
- upd held high: the shadow follows din every cycle.
- co_in held high: only one event is generated; a new event requires co_in to drop and rise again.

## Structure
- Shared package seg_pkg:
  - SEG_BLANK constant (7'h7F)
  - 16-entry hex-to-segment constant table
  - DIGITS=4 constant
- Sub-module seg_hex_decode: combinational 4-bit → 7-bit active-low decoder using the seg_pkg table. It is reused by other display blocks.
- Top level contains the prescaler, index, shadow, blanking logic, hold counter and output registers.

## Test plan
All scenarios use DIV=4, HOLD_SCANS=2.
- Reset: drive mr_n=0 mid-run → an=1111, seg=0x7F, dp_n=1 with no clk edge. Release → next edge an=1110, seg=0x40.
- Scan/decode: din=16'h3210, single upd pulse, blank_lz=0 → an steps 1110/1101/1011/0111, 4 cycles each, with seg 0x40/0x79/0x24/0x30. The sequence repeats every 16 cycles.
- Blanking: din=16'h0003, blank_lz=1 → digits 3–1 seg=0x7F, digit 0 seg=0x30. Then din=16'h0000 → digit 0 seg=0x40, others blank. With blank_lz=0 → all digits 0x40.
- Snapshot hold: change din to 16'hFFFF without upd → display unchanged. Pulse upd → every digit shows 0x0E from the next cycle.
- Overflow:
  - co_in 0→1 → dp_n=0 during the digit-3 slot for exactly 2 full scans, then stays 1.
  - co_in held high does not retrigger.
  - A second rising edge during the hold reloads the count to 2.
- Simultaneous events: co_in rising edge in the same cycle as a scan completion while hold=1 → hold counter becomes 2, not 0.
